// File: rtl/tft_timing_gen_if.sv
// Pixel stream and panel bus bundle for tft_timing_gen.
// master: the timing generator (pulls pixels, drives the panel).
// slave : the surrounding logic (supplies pixels, observes the panel).
interface tft_timing_gen_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] pixel_data;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [DATA_WIDTH-1:0] tft_data;
  logic                  tft_hsync_n;
  logic                  tft_vsync_n;
  logic                  tft_de;

  modport master (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready,
    output tft_data,
    output tft_hsync_n,
    output tft_vsync_n,
    output tft_de
  );

  modport slave (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready,
    input  tft_data,
    input  tft_hsync_n,
    input  tft_vsync_n,
    input  tft_de
  );
endinterface

// File: rtl/tft_timing_gen.sv
// Raster timing generator and pixel pump for the TFT panel.
// Steps the h/v position once per rising edge of the divided pclk, which is sampled in the
// clk domain, and loads hsync/vsync/de/data registers from the decode of the position.
module tft_timing_gen #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned H_FP       = 2,
  parameter int unsigned H_SYNC     = 41,
  parameter int unsigned H_BP       = 2,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned V_FP       = 2,
  parameter int unsigned V_SYNC     = 10,
  parameter int unsigned V_BP       = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_pclk,
  input  logic                  i_lock,
  tft_timing_gen_if.master      if_tft,
  output logic [15:0]           o_x,
  output logic [15:0]           o_y,
  output logic                  o_frame_start,
  output logic                  o_underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] H_SYNC_S = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] H_SYNC_E = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_SYNC_S = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_E = 16'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_size_check
    $error("tft_timing_gen: H_TOTAL/V_TOTAL do not fit the 16-bit counters");
  end

  logic                  r_pclk_d;
  logic [15:0]           r_h_cnt;
  logic [15:0]           r_v_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hsync_n;
  logic                  r_vsync_n;
  logic                  r_de;
  logic [15:0]           r_x;
  logic [15:0]           r_y;
  logic                  r_frame_start;

  logic w_pix_en;
  logic w_run;
  logic w_active;
  logic w_hsync;
  logic w_vsync;
  logic w_step;
  logic w_ready;

  // Position decode and the one-clk pixel step; reset gating keeps ready low while held in reset.
  always_comb begin
    w_pix_en = i_pclk & ~r_pclk_d & i_rst_n;
    w_run    = i_enable & i_lock;
    w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_hsync  = (r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E);
    w_vsync  = (r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E);
    w_step   = w_pix_en & w_run;
    w_ready  = w_step & w_active;
  end

  // pclk edge detector register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pclk_d <= 1'b0;
    end else begin
      r_pclk_d <= i_pclk;
    end
  end

  // Raster counters: h wraps at H_TOTAL-1 and carries into v; dropping run restarts the frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= 16'd0;
      r_v_cnt <= 16'd0;
    end else if (!w_run) begin
      r_h_cnt <= 16'd0;
      r_v_cnt <= 16'd0;
    end else if (w_pix_en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= 16'd0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? 16'd0 : r_v_cnt + 16'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 16'd1;
      end
    end
  end

  // Panel outputs load from the current position on each step and hold between steps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data        <= '0;
      r_hsync_n     <= 1'b1;
      r_vsync_n     <= 1'b1;
      r_de          <= 1'b0;
      r_x           <= 16'd0;
      r_y           <= 16'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (!w_run) begin
        r_data    <= '0;
        r_hsync_n <= 1'b1;
        r_vsync_n <= 1'b1;
        r_de      <= 1'b0;
        r_x       <= 16'd0;
        r_y       <= 16'd0;
      end else if (w_pix_en) begin
        r_hsync_n     <= ~w_hsync;
        r_vsync_n     <= ~w_vsync;
        r_frame_start <= (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
        if (w_active) begin
          // An underflow still shows a (black) active pixel so the raster keeps its geometry.
          r_data <= if_tft.pixel_valid ? if_tft.pixel_data : '0;
          r_de   <= 1'b1;
          r_x    <= r_h_cnt;
          r_y    <= r_v_cnt;
        end else begin
          r_data <= '0;
          r_de   <= 1'b0;
          r_x    <= 16'd0;
          r_y    <= 16'd0;
        end
      end
    end
  end

  assign if_tft.pixel_ready = w_ready;
  assign if_tft.tft_data    = r_data;
  assign if_tft.tft_hsync_n = r_hsync_n;
  assign if_tft.tft_vsync_n = r_vsync_n;
  assign if_tft.tft_de      = r_de;
  assign o_x                = r_x;
  assign o_y                = r_y;
  assign o_frame_start      = r_frame_start;
  assign o_underflow        = w_ready & ~if_tft.pixel_valid;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen with shrunk raster (8 steps/line, 6 lines/frame, pclk = clk/4).
// The reference model tracks a linear pixel index within the frame and derives position and
// expected outputs from it arithmetically; directed checks pin the model with literal values.
module tb_tft_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic lock = 1'b0;
  logic pclk = 1'b0;
  logic [15:0] x, y;
  logic frame_start, underflow;

  tft_timing_gen_if #(.DATA_WIDTH(24)) u_if ();

  tft_timing_gen #(
    .DATA_WIDTH(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pclk(pclk), .i_lock(lock),
    .if_tft(u_if.master), .o_x(x), .o_y(y), .o_frame_start(frame_start),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ph(int n); return n % HT; endfunction
  function automatic int pv(int n); return n / HT; endfunction
  function automatic bit pact(int n); return ph(n) < HA && pv(n) < VA; endfunction

  // Reference model: m_n is the index of the next pixel position in the frame.
  int          m_n;
  logic        m_pd, m_loaded;
  logic [23:0] e_data;
  logic        e_hs, e_vs, e_de, e_fs;
  int          e_x, e_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pd <= 1'b0; m_n <= 0; m_loaded <= 1'b0;
      e_data <= '0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_x <= 0; e_y <= 0; e_fs <= 1'b0;
    end else begin
      m_pd     <= pclk;
      m_loaded <= 1'b0;
      e_fs     <= 1'b0;
      if (!(enable && lock)) begin
        m_n <= 0;
        e_data <= '0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_x <= 0; e_y <= 0;
      end else if (pclk && !m_pd) begin
        m_loaded <= 1'b1;
        e_de     <= pact(m_n);
        e_data   <= (pact(m_n) && u_if.pixel_valid) ? u_if.pixel_data : 24'h0;
        e_x      <= pact(m_n) ? ph(m_n) : 0;
        e_y      <= pact(m_n) ? pv(m_n) : 0;
        e_hs     <= !(ph(m_n) >= HA + HF && ph(m_n) < HA + HF + HS);
        e_vs     <= !(pv(m_n) >= VA + VF && pv(m_n) < VA + VF + VS);
        e_fs     <= (m_n == 0);
        m_n      <= (m_n + 1) % FT;
      end
    end
  end

  // Per-cycle compare plus capture of the DUT outputs after each step.
  logic chk_on = 1'b0;
  logic rec_on = 1'b0;
  int   obs_cnt = 0;
  int   uf_cnt = 0;
  int   rdy_cnt = 0;
  logic [23:0] obs_data [0:127];
  logic        obs_de [0:127];
  logic        obs_hs [0:127];
  logic        obs_vs [0:127];
  logic        obs_fs [0:127];

  always @(negedge clk) begin
    logic e_ready;
    e_ready = rst_n && pclk && !m_pd && enable && lock && pact(m_n);
    if (underflow) uf_cnt++;
    if (u_if.pixel_ready) rdy_cnt++;
    if (chk_on) begin
      chk("pixel_ready", 32'(u_if.pixel_ready), 32'(e_ready));
      chk("underflow", 32'(underflow), 32'(e_ready && !u_if.pixel_valid));
      chk("tft_data", 32'(u_if.tft_data), 32'(e_data));
      chk("hsync_n", 32'(u_if.tft_hsync_n), 32'(e_hs));
      chk("vsync_n", 32'(u_if.tft_vsync_n), 32'(e_vs));
      chk("de", 32'(u_if.tft_de), 32'(e_de));
      chk("x", 32'(x), 32'(e_x));
      chk("y", 32'(y), 32'(e_y));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
    end
    if (rec_on && m_loaded && obs_cnt < 128) begin
      obs_data[obs_cnt] = u_if.tft_data;
      obs_de[obs_cnt]   = u_if.tft_de;
      obs_hs[obs_cnt]   = u_if.tft_hsync_n;
      obs_vs[obs_cnt]   = u_if.tft_vsync_n;
      obs_fs[obs_cnt]   = frame_start;
      obs_cnt++;
    end
  end

  // pclk is a clk-domain register toggled every 2 clk unless stalled; data = h + 256*v.
  logic stall = 1'b0;
  int   pc_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (!stall) begin
      pc_cnt++;
      if (pc_cnt == 2) begin
        pclk = ~pclk;
        pc_cnt = 0;
      end
    end
    u_if.pixel_data = 24'(ph(m_n) + 256 * pv(m_n));
  endtask

  task automatic wait_pos(input int target, input string nm);
    int n;
    n = 0;
    while (m_n != target && n < 1000) begin
      tick();
      n++;
    end
    if (m_n != target) chk({nm, "_timeout"}, 32'(m_n), 32'(target));
  endtask

  task automatic wait_step(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_loaded && n < 20);
    if (!m_loaded) chk({nm, "_timeout"}, 32'(m_loaded), 32'd1);
  endtask

  initial begin
    int vs_low, fs_cnt, uf0, rdy0;
    logic [23:0] s_data;
    logic [15:0] s_x, s_y;
    logic        s_de, s_hs, s_vs;

    u_if.pixel_data  = '0;
    u_if.pixel_valid = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    enable = 1'b1;
    lock   = 1'b1;
    tick();
    rec_on = 1'b1;
    rst_n  = 1'b1;

    // One line / two frames of timing with a valid stream.
    for (int i = 0; i < 1200 && obs_cnt < 100; i++) tick();
    rec_on = 1'b0;
    chk("obs_count", 32'(obs_cnt >= 100), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("line_de_active", 32'(obs_de[k]), 32'd1);
      chk("line_data", 32'(obs_data[k]), 32'(k));
    end
    for (int k = 4; k < 8; k++) chk("line_de_blank", 32'(obs_de[k]), 32'd0);
    chk("hsync_step4", 32'(obs_hs[4]), 32'd1);
    chk("hsync_step5", 32'(obs_hs[5]), 32'd0);
    chk("hsync_step6", 32'(obs_hs[6]), 32'd0);
    chk("hsync_step7", 32'(obs_hs[7]), 32'd1);
    chk("line1_data0", 32'(obs_data[8]), 32'h100);
    vs_low = 0;
    fs_cnt = 0;
    for (int k = 0; k < 48; k++) if (!obs_vs[k]) vs_low++;
    for (int k = 0; k < 100; k++) if (obs_fs[k]) fs_cnt++;
    chk("vsync_low_steps", 32'(vs_low), 32'd8);
    chk("vsync_step31", 32'(obs_vs[31]), 32'd1);
    chk("vsync_step32", 32'(obs_vs[32]), 32'd0);
    chk("vsync_step39", 32'(obs_vs[39]), 32'd0);
    chk("vsync_step40", 32'(obs_vs[40]), 32'd1);
    chk("fs_step0", 32'(obs_fs[0]), 32'd1);
    chk("fs_step48", 32'(obs_fs[48]), 32'd1);
    chk("fs_count", 32'(fs_cnt), 32'd3);

    // Underflow at (2,1), then (3,1) consumed normally.
    wait_pos(HT + 2, "uf_wait");
    uf0 = uf_cnt;
    u_if.pixel_valid = 1'b0;
    wait_step("uf_step");
    chk("uf_data", 32'(u_if.tft_data), 32'd0);
    chk("uf_de", 32'(u_if.tft_de), 32'd1);
    chk("uf_x", 32'(x), 32'd2);
    chk("uf_y", 32'(y), 32'd1);
    chk("uf_pulses", 32'(uf_cnt - uf0), 32'd1);
    u_if.pixel_valid = 1'b1;
    wait_step("uf_next");
    chk("next_data", 32'(u_if.tft_data), 32'h103);
    chk("next_x", 32'(x), 32'd3);
    chk("next_y", 32'(y), 32'd1);
    chk("uf_no_more", 32'(uf_cnt - uf0), 32'd1);

    // Lock drop at (1,2) for 10 clk, then restart from (0,0).
    wait_pos(2 * HT + 1, "lock_wait");
    lock = 1'b0;
    tick();
    tick();
    chk("drop_de", 32'(u_if.tft_de), 32'd0);
    chk("drop_hs", 32'(u_if.tft_hsync_n), 32'd1);
    chk("drop_vs", 32'(u_if.tft_vsync_n), 32'd1);
    chk("drop_data", 32'(u_if.tft_data), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    lock = 1'b1;
    wait_step("restart");
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk("restart_x", 32'(x), 32'd0);
    chk("restart_y", 32'(y), 32'd0);
    chk("restart_de", 32'(u_if.tft_de), 32'd1);

    // pclk stalled high for 20 clk.
    for (int i = 0; i < 30 && pclk !== 1'b1; i++) tick();
    stall = 1'b1;
    tick();
    tick();
    s_data = u_if.tft_data; s_x = x; s_y = y;
    s_de = u_if.tft_de; s_hs = u_if.tft_hsync_n; s_vs = u_if.tft_vsync_n;
    rdy0 = rdy_cnt;
    for (int i = 0; i < 18; i++) tick();
    chk("stall_ready", 32'(rdy_cnt - rdy0), 32'd0);
    chk("stall_data", 32'(u_if.tft_data), 32'(s_data));
    chk("stall_xy", {x, y}, {s_x, s_y});
    chk("stall_ctl", 32'({u_if.tft_de, u_if.tft_hsync_n, u_if.tft_vsync_n}),
        32'({s_de, s_hs, s_vs}));
    stall = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Asynchronous reset mid-frame.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_data", 32'(u_if.tft_data), 32'd0);
    chk("rst_syncs", 32'({u_if.tft_hsync_n, u_if.tft_vsync_n}), 32'd3);
    chk("rst_de", 32'(u_if.tft_de), 32'd0);
    chk("rst_xy", {x, y}, 32'd0);
    chk("rst_pulses", 32'({frame_start, underflow, u_if.pixel_ready}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_step("post_rst");
    chk("post_rst_fs", 32'(frame_start), 32'd1);
    chk("post_rst_xy", {x, y}, 32'd0);
    chk("post_rst_de", 32'(u_if.tft_de), 32'd1);
    for (int i = 0; i < 60; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
